// File: rtl/sha_round_ctrl_pkg.sv
// Shared types and defaults for the SHA-256 round sequencer.
// Build option: define SHA_T3_PRECALC_EN to enable the T3 precalculation stage.
package sha_round_ctrl_pkg;

   localparam int unsigned NUM_ROUNDS_DEF = 64;
   localparam int unsigned CNT_W_DEF      = 6;

   // ST_PRE is only reachable when the T3 precalculation stage is built in
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_PRE   = 3'd2,
      ST_ROUND = 3'd3,
      ST_FINAL = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

endpackage

// File: rtl/sha_round_ctrl_counter.sv
// Round counter: clear has priority over enable; terminal flag at NUM_ROUNDS-1.
module sha_round_counter
   import sha_round_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W      = CNT_W_DEF,
   parameter int unsigned NUM_ROUNDS = NUM_ROUNDS_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_tc_c
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ROUNDS - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Next count: cleared back to zero before it could ever wrap
   always_comb begin
      cnt_d = cnt_q;
      if (i_clr) begin
         cnt_d = '0;
      end else if (i_en) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Count register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign o_cnt  = cnt_q;
   assign o_tc_c = (cnt_q == LAST);

endmodule

// File: rtl/sha_round_ctrl.sv
// SHA-256 compression sequencer: LOAD, [PRE], ROUND x NUM_ROUNDS, FINAL, DONE.
// Build option: SHA_T3_PRECALC_EN adds the PRE state and T3/K-index lookahead.
module sha_round_ctrl
   import sha_round_ctrl_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = NUM_ROUNDS_DEF,
   parameter int unsigned CNT_W      = CNT_W_DEF
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_blk_vld,
   output logic             o_blk_rdy,
   input  logic             i_first,
   output logic             o_sel_iv,
   output logic             o_ld_init,
   output logic             o_rnd_en,
   output logic             o_sched_en,
   output logic [CNT_W-1:0] o_round,
   output logic [CNT_W-1:0] o_kt_idx,
   output logic             o_t3_en,
   output logic             o_fin_en,
   output logic             o_digest_vld,
   input  logic             i_digest_rdy,
   output logic             o_busy
);

   state_e           state_q;
   state_e           state_d;
   logic             accept_c;
   logic             blk_rdy_c;
   logic             cnt_clr_c;
   logic             cnt_en_c;
   logic             cnt_tc_c;
   logic [CNT_W-1:0] cnt;
   logic             sel_iv_q;
   logic             ld_init_q;
   logic             rnd_en_q;
   logic             fin_en_q;
   logic             digest_vld_q;
   logic             busy_q;

   assign blk_rdy_c = (state_q == ST_IDLE) || ((state_q == ST_DONE) && i_digest_rdy);
   assign accept_c  = i_blk_vld && blk_rdy_c;
   assign cnt_en_c  = (state_q == ST_ROUND);
   assign cnt_clr_c = (state_q == ST_LOAD) || ((state_q == ST_ROUND) && cnt_tc_c);

   sha_round_counter #(
      .CNT_W      (CNT_W),
      .NUM_ROUNDS (NUM_ROUNDS)
   ) u_cnt (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_clr  (cnt_clr_c),
      .i_en   (cnt_en_c),
      .o_cnt  (cnt),
      .o_tc_c (cnt_tc_c)
   );

   // Next-state decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept_c) state_d = ST_LOAD;
`ifdef SHA_T3_PRECALC_EN
         ST_LOAD:  state_d = ST_PRE;
`else
         ST_LOAD:  state_d = ST_ROUND;
`endif
         ST_PRE:   state_d = ST_ROUND;
         ST_ROUND: if (cnt_tc_c) state_d = ST_FINAL;
         ST_FINAL: state_d = ST_DONE;
         ST_DONE:  if (i_digest_rdy) state_d = i_blk_vld ? ST_LOAD : ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // State register and strobes registered from the upcoming state
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q      <= ST_IDLE;
         sel_iv_q     <= 1'b1;
         ld_init_q    <= 1'b0;
         rnd_en_q     <= 1'b0;
         fin_en_q     <= 1'b0;
         digest_vld_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         if (accept_c) begin
            sel_iv_q <= i_first;
         end
         ld_init_q    <= (state_d == ST_LOAD);
         rnd_en_q     <= (state_d == ST_ROUND);
         fin_en_q     <= (state_d == ST_FINAL);
         digest_vld_q <= (state_d == ST_DONE);
         busy_q       <= (state_d != ST_IDLE);
      end
   end

`ifdef SHA_T3_PRECALC_EN
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_ROUNDS - 1);

   logic [CNT_W-1:0] round_nxt_c;
   logic             t3_en_q;
   logic [CNT_W-1:0] kt_idx_q;

   assign round_nxt_c = ((state_q == ST_ROUND) && (state_d == ST_ROUND)) ? cnt + CNT_W'(1) : '0;

   // K index runs one round ahead so T3 can be precomputed; last round has nothing to prefetch
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         t3_en_q  <= 1'b0;
         kt_idx_q <= '0;
      end else begin
         t3_en_q  <= (state_d == ST_PRE) || ((state_d == ST_ROUND) && (round_nxt_c != LAST));
         kt_idx_q <= ((state_d == ST_ROUND) && (round_nxt_c != LAST)) ? round_nxt_c + CNT_W'(1) : '0;
      end
   end

   assign o_t3_en  = t3_en_q;
   assign o_kt_idx = kt_idx_q;
`else
   assign o_t3_en  = 1'b0;
   assign o_kt_idx = cnt;
`endif

   assign o_blk_rdy    = blk_rdy_c;
   assign o_sel_iv     = sel_iv_q;
   assign o_ld_init    = ld_init_q;
   assign o_rnd_en     = rnd_en_q;
   assign o_sched_en   = rnd_en_q;
   assign o_round      = cnt;
   assign o_fin_en     = fin_en_q;
   assign o_digest_vld = digest_vld_q;
   assign o_busy       = busy_q;

endmodule

// File: tb/tb_sha_round_ctrl.sv
// Directed bench for sha_round_ctrl (full-round instance plus a 4-round instance).
module tb_sha_round_ctrl;

   localparam int unsigned NR  = 64;
   localparam int unsigned CW  = 6;
   localparam int unsigned NR2 = 4;
   localparam int unsigned CW2 = 3;
`ifdef SHA_T3_PRECALC_EN
   localparam int PRE = 1;
`else
   localparam int PRE = 0;
`endif
   // edges from the LOAD sample to the DONE sample
   localparam int LAT = 66 + PRE;

   // strobe vector: {ld_init, rnd_en, sched_en, fin_en, digest_vld, t3_en}
   localparam logic [5:0] S_NONE  = 6'b000000;
   localparam logic [5:0] S_LOAD  = 6'b100000;
   localparam logic [5:0] S_ROUND = 6'b011000;
   localparam logic [5:0] S_FINAL = 6'b000100;
   localparam logic [5:0] S_DONE  = 6'b000010;
   localparam logic [5:0] S_PRE   = 6'b000001;

   logic clk = 1'b0;
   logic rst;
   logic blk_vld, first, digest_rdy;
   logic blk_rdy, sel_iv, ld_init, rnd_en, sched_en, t3_en, fin_en, digest_vld, busy;
   logic [CW-1:0] round, kt_idx;

   logic blk_vld2, first2, digest_rdy2;
   logic blk_rdy2, sel_iv2, ld_init2, rnd_en2, sched_en2, t3_en2, fin_en2, digest_vld2, busy2;
   logic [CW2-1:0] round2, kt_idx2;

   logic [5:0] strb;
   assign strb = {ld_init, rnd_en, sched_en, fin_en, digest_vld, t3_en};

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   sha_round_ctrl #(.NUM_ROUNDS(NR), .CNT_W(CW)) dut (
      .i_clk(clk), .i_rst(rst), .i_blk_vld(blk_vld), .o_blk_rdy(blk_rdy), .i_first(first),
      .o_sel_iv(sel_iv), .o_ld_init(ld_init), .o_rnd_en(rnd_en), .o_sched_en(sched_en),
      .o_round(round), .o_kt_idx(kt_idx), .o_t3_en(t3_en), .o_fin_en(fin_en),
      .o_digest_vld(digest_vld), .i_digest_rdy(digest_rdy), .o_busy(busy)
   );

   sha_round_ctrl #(.NUM_ROUNDS(NR2), .CNT_W(CW2)) dut4 (
      .i_clk(clk), .i_rst(rst), .i_blk_vld(blk_vld2), .o_blk_rdy(blk_rdy2), .i_first(first2),
      .o_sel_iv(sel_iv2), .o_ld_init(ld_init2), .o_rnd_en(rnd_en2), .o_sched_en(sched_en2),
      .o_round(round2), .o_kt_idx(kt_idx2), .o_t3_en(t3_en2), .o_fin_en(fin_en2),
      .o_digest_vld(digest_vld2), .i_digest_rdy(digest_rdy2), .o_busy(busy2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      blk_vld = 1'b0; first = 1'b0; digest_rdy = 1'b0;
      blk_vld2 = 1'b0; first2 = 1'b0; digest_rdy2 = 1'b0;
      step();
      step();
      n_tests++;
      if (strb !== S_NONE || blk_rdy !== 1'b1 || sel_iv !== 1'b1 || busy !== 1'b0 ||
          round !== '0 || kt_idx !== '0) begin
         n_fail++;
         $display("FAIL reset_hold: strb=%b rdy=%b sel_iv=%b busy=%b round=%0d kt=%0d, want 000000 1 1 0 0 0",
                  strb, blk_rdy, sel_iv, busy, round, kt_idx);
      end
      rst = 1'b0;
      step();
      n_tests++;
      if (strb !== S_NONE || blk_rdy !== 1'b1 || sel_iv !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle: strb=%b rdy=%b sel_iv=%b busy=%b, want 000000 1 1 0",
                  strb, blk_rdy, sel_iv, busy);
      end
   endtask

   task automatic test_single_block();
      logic [5:0]    es;
      logic [CW-1:0] ek;
      blk_vld = 1'b1; first = 1'b1; digest_rdy = 1'b1;
      step();
      blk_vld = 1'b0;
      n_tests++;
      if (strb !== S_LOAD || sel_iv !== 1'b1 || busy !== 1'b1 || round !== '0) begin
         n_fail++;
         $display("FAIL single_load: strb=%b sel_iv=%b busy=%b round=%0d, want %b 1 1 0",
                  strb, sel_iv, busy, round, S_LOAD);
      end
`ifdef SHA_T3_PRECALC_EN
      step();
      n_tests++;
      if (strb !== S_PRE || kt_idx !== '0 || round !== '0) begin
         n_fail++;
         $display("FAIL single_pre: strb=%b kt=%0d round=%0d, want %b 0 0", strb, kt_idx, round, S_PRE);
      end
`endif
      for (int r = 0; r < int'(NR); r++) begin
         step();
`ifdef SHA_T3_PRECALC_EN
         ek = (r == int'(NR) - 1) ? '0 : CW'(r + 1);
         es = S_ROUND | ((r == int'(NR) - 1) ? 6'b000000 : 6'b000001);
`else
         ek = CW'(r);
         es = S_ROUND;
`endif
         n_tests++;
         if (strb !== es || round !== CW'(r) || kt_idx !== ek || sel_iv !== 1'b1) begin
            n_fail++;
            $display("FAIL single_round%0d: strb=%b round=%0d kt=%0d sel_iv=%b, want %b %0d %0d 1",
                     r, strb, round, kt_idx, sel_iv, es, r, ek);
         end
      end
      step();
      n_tests++;
      if (strb !== S_FINAL || round !== '0 || kt_idx !== '0 || sel_iv !== 1'b1) begin
         n_fail++;
         $display("FAIL single_final: strb=%b round=%0d kt=%0d sel_iv=%b, want %b 0 0 1",
                  strb, round, kt_idx, sel_iv, S_FINAL);
      end
      step();
      n_tests++;
      if (strb !== S_DONE || blk_rdy !== 1'b1 || sel_iv !== 1'b1) begin
         n_fail++;
         $display("FAIL single_done: strb=%b rdy=%b sel_iv=%b, want %b 1 1", strb, blk_rdy, sel_iv, S_DONE);
      end
      step();
      n_tests++;
      if (strb !== S_NONE || busy !== 1'b0 || blk_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_idle: strb=%b busy=%b rdy=%b, want 000000 0 1", strb, busy, blk_rdy);
      end
   endtask

   task automatic test_back_to_back();
      int t1;
      int t2;
      blk_vld = 1'b1; first = 1'b1; digest_rdy = 1'b1;
      step();
      first = 1'b0;
      t1 = 0;
      while (digest_vld !== 1'b1 && t1 < 200) begin
         step();
         t1++;
      end
      n_tests++;
      if (t1 !== LAT || sel_iv !== 1'b1 || blk_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_first_done: edges=%0d sel_iv=%b rdy=%b, want %0d 1 1", t1, sel_iv, blk_rdy, LAT);
      end
      step();
      blk_vld = 1'b0;
      n_tests++;
      if (strb !== S_LOAD || sel_iv !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_second_load: strb=%b sel_iv=%b, want %b 0", strb, sel_iv, S_LOAD);
      end
      t2 = 0;
      while (digest_vld !== 1'b1 && t2 < 200) begin
         step();
         t2++;
      end
      n_tests++;
      if (t1 + 1 + t2 !== 2 * LAT + 1 || sel_iv !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_total: edges=%0d sel_iv=%b, want %0d 0", t1 + 1 + t2, sel_iv, 2 * LAT + 1);
      end
      step();
      n_tests++;
      if (busy !== 1'b0 || strb !== S_NONE) begin
         n_fail++;
         $display("FAIL b2b_idle: busy=%b strb=%b, want 0 000000", busy, strb);
      end
   endtask

   task automatic test_digest_stall();
      int t;
      blk_vld = 1'b1; first = 1'b1; digest_rdy = 1'b0;
      step();
      t = 0;
      while (digest_vld !== 1'b1 && t < 200) begin
         step();
         t++;
      end
      n_tests++;
      if (t !== LAT) begin
         n_fail++;
         $display("FAIL stall_latency: edges=%0d, want %0d", t, LAT);
      end
      for (int i = 0; i < 10; i++) begin
         step();
         n_tests++;
         if (strb !== S_DONE || blk_rdy !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_hold%0d: strb=%b rdy=%b busy=%b, want %b 0 1", i, strb, blk_rdy, busy, S_DONE);
         end
      end
      digest_rdy = 1'b1;
      #1;
      n_tests++;
      if (blk_rdy !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_release_rdy: rdy=%b, want 1", blk_rdy);
      end
      step();
      blk_vld = 1'b0;
      n_tests++;
      if (strb !== S_LOAD) begin
         n_fail++;
         $display("FAIL stall_release_load: strb=%b, want %b", strb, S_LOAD);
      end
      t = 0;
      while (digest_vld !== 1'b1 && t < 200) begin
         step();
         t++;
      end
      step();
      n_tests++;
      if (t !== LAT || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_drain: edges=%0d busy=%b, want %0d 0", t, busy, LAT);
      end
   endtask

   task automatic test_reset_mid_block();
      int t;
      int fins;
      blk_vld = 1'b1; first = 1'b1; digest_rdy = 1'b1;
      step();
      blk_vld = 1'b0;
      t = 0;
      while (!(rnd_en === 1'b1 && round === CW'(30)) && t < 200) begin
         step();
         t++;
      end
      n_tests++;
      if (t !== 31 + PRE) begin
         n_fail++;
         $display("FAIL abort_reach_r30: edges=%0d, want %0d", t, 31 + PRE);
      end
      rst = 1'b1;
      step();
      n_tests++;
      if (strb !== S_NONE || blk_rdy !== 1'b1 || busy !== 1'b0 || round !== '0 || sel_iv !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_idle: strb=%b rdy=%b busy=%b round=%0d sel_iv=%b, want 000000 1 0 0 1",
                  strb, blk_rdy, busy, round, sel_iv);
      end
      rst = 1'b0;
      step();
      blk_vld = 1'b1; first = 1'b0;
      step();
      blk_vld = 1'b0;
      n_tests++;
      if (strb !== S_LOAD || sel_iv !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_fresh_load: strb=%b sel_iv=%b, want %b 0", strb, sel_iv, S_LOAD);
      end
      t = 0;
      fins = 0;
      while (digest_vld !== 1'b1 && t < 200) begin
         step();
         t++;
         if (fin_en === 1'b1) fins++;
      end
      n_tests++;
      if (t !== LAT || fins !== 1) begin
         n_fail++;
         $display("FAIL abort_fresh_block: edges=%0d fin_pulses=%0d, want %0d 1", t, fins, LAT);
      end
      step();
   endtask

   task automatic test_reduced_rounds();
      int t;
      int rcnt;
      int rmax;
      blk_vld2 = 1'b1; first2 = 1'b1; digest_rdy2 = 1'b1;
      step();
      blk_vld2 = 1'b0;
      n_tests++;
      if (ld_init2 !== 1'b1 || rnd_en2 !== 1'b0) begin
         n_fail++;
         $display("FAIL nr4_load: ld_init=%b rnd_en=%b, want 1 0", ld_init2, rnd_en2);
      end
      t = 0;
      rcnt = 0;
      rmax = 0;
      while (digest_vld2 !== 1'b1 && t < 50) begin
         step();
         t++;
         if (int'(round2) > rmax) rmax = int'(round2);
         if (rnd_en2 === 1'b1) begin
            n_tests++;
            if (round2 !== CW2'(rcnt) || sched_en2 !== 1'b1) begin
               n_fail++;
               $display("FAIL nr4_round%0d: round=%0d sched_en=%b, want %0d 1", rcnt, round2, sched_en2, rcnt);
            end
            rcnt++;
         end
      end
      n_tests++;
      if (rcnt !== int'(NR2) || rmax !== int'(NR2) - 1 || t !== int'(NR2) + 2 + PRE) begin
         n_fail++;
         $display("FAIL nr4_summary: rounds=%0d max_round=%0d edges=%0d, want %0d %0d %0d",
                  rcnt, rmax, t, NR2, NR2 - 1, NR2 + 2 + PRE);
      end
      step();
      n_tests++;
      if (busy2 !== 1'b0 || round2 !== '0) begin
         n_fail++;
         $display("FAIL nr4_idle: busy=%b round=%0d, want 0 0", busy2, round2);
      end
   endtask

   initial begin
      test_reset();
      test_single_block();
      test_back_to_back();
      test_digest_stall();
      test_reset_mid_block();
      test_reduced_rounds();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", n_tests);
      $fatal(1, "watchdog");
   end

endmodule
